// File: rtl/cache_line_fill_if.sv
// cache_line_fill_if: miss, writeback/refill memory and fill-return signals of the line-fill stage.
interface cache_line_fill_if #(
    parameter int LINE_SIZE_BYTES = 64,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_WIDTH   = 32
);
    logic                         miss_valid;
    logic                         miss_ready;
    logic [ADDRESS_WIDTH-1:0]     miss_addr;
    logic                         wb_dirty;
    logic [ADDRESS_WIDTH-1:0]     wb_addr;
    logic [LINE_SIZE_BYTES*8-1:0] wb_line;
    logic                         mem_req_valid;
    logic                         mem_req_ready;
    logic                         mem_req_we;
    logic [ADDRESS_WIDTH-1:0]     mem_req_addr;
    logic [DATA_WIDTH-1:0]        mem_wdata;
    logic                         mem_rdata_valid;
    logic [DATA_WIDTH-1:0]        mem_rdata;
    logic                         fill_valid;
    logic                         fill_ready;
    logic [ADDRESS_WIDTH-1:0]     fill_addr;
    logic [LINE_SIZE_BYTES*8-1:0] fill_line;
    logic                         busy;

    modport master (
        input  miss_valid, miss_addr, wb_dirty, wb_addr, wb_line,
               mem_req_ready, mem_rdata_valid, mem_rdata, fill_ready,
        output miss_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_wdata,
               fill_valid, fill_addr, fill_line, busy
    );

    modport slave (
        output miss_valid, miss_addr, wb_dirty, wb_addr, wb_line,
               mem_req_ready, mem_rdata_valid, mem_rdata, fill_ready,
        input  miss_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_wdata,
               fill_valid, fill_addr, fill_line, busy
    );
endinterface

// File: rtl/cache_line_fill.sv
// cache_line_fill: single-outstanding miss handler; optional dirty-victim writeback, line refill, fill return.
module cache_line_fill #(
    parameter int LINE_SIZE_BYTES = 64,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int OFFSET_BITS     = 6
) (
    input  logic clk,
    input  logic rst,
    cache_line_fill_if.master bus
);
    localparam int BEATS = LINE_SIZE_BYTES * 8 / DATA_WIDTH;
    localparam int BW    = $clog2(BEATS);
    localparam int LW    = LINE_SIZE_BYTES * 8;
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN = {{(ADDRESS_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

    typedef enum logic [2:0] {IDLE, WB, RD_REQ, RD_DATA, FILL} state_t;

    state_t                   state_q, state_d;
    logic [BW-1:0]            beat_q, beat_d;
    logic [LW-1:0]            line_q, line_d;
    logic [ADDRESS_WIDTH-1:0] miss_addr_q, miss_addr_d;
    logic [ADDRESS_WIDTH-1:0] wb_addr_q, wb_addr_d;
    logic                     last;

    assign last = beat_q == BW'(BEATS - 1);

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        line_d      = line_q;
        miss_addr_d = miss_addr_q;
        wb_addr_d   = wb_addr_q;
        case (state_q)
            IDLE: if (bus.miss_valid) begin
                miss_addr_d = bus.miss_addr & ALIGN;
                wb_addr_d   = bus.wb_addr & ALIGN;
                line_d      = bus.wb_line;
                state_d     = bus.wb_dirty ? WB : RD_REQ;
            end
            WB: if (bus.mem_req_ready) begin
                beat_d  = last ? '0 : beat_q + 1'b1;
                state_d = last ? RD_REQ : WB;
            end
            RD_REQ: state_d = bus.mem_req_ready ? RD_DATA : RD_REQ;
            RD_DATA: if (bus.mem_rdata_valid) begin
                line_d[int'(beat_q)*DATA_WIDTH +: DATA_WIDTH] = bus.mem_rdata;
                beat_d  = last ? '0 : beat_q + 1'b1;
                state_d = last ? FILL : RD_DATA;
            end
            FILL: state_d = bus.fill_ready ? IDLE : FILL;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            line_q      <= '0;
            miss_addr_q <= '0;
            wb_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            line_q      <= line_d;
            miss_addr_q <= miss_addr_d;
            wb_addr_q   <= wb_addr_d;
        end
    end

    // Outputs decode straight from flops; data/address buses are zeroed outside the states that own them.
    assign bus.miss_ready    = state_q == IDLE;
    assign bus.busy          = state_q != IDLE;
    assign bus.mem_req_valid = state_q == WB || state_q == RD_REQ;
    assign bus.mem_req_we    = state_q == WB;
    assign bus.mem_req_addr  = state_q == WB ? wb_addr_q + ADDRESS_WIDTH'((DATA_WIDTH / 8) * int'(beat_q)) :
                               state_q == RD_REQ ? miss_addr_q : '0;
    assign bus.mem_wdata     = state_q == WB ? line_q[int'(beat_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.fill_valid    = state_q == FILL;
    assign bus.fill_addr     = state_q == FILL ? miss_addr_q : '0;
    assign bus.fill_line     = state_q == FILL ? line_q : '0;
endmodule

// File: tb/tb_cache_line_fill.sv
// tb_cache_line_fill: randomized miss traffic against a line-level model of writeback beats and refill contents.
module tb_cache_line_fill;
    logic clk = 0;
    logic rst = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    cache_line_fill_if bus ();
    cache_line_fill dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_miss_ready", bus.miss_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_req_valid", bus.mem_req_valid, 0);
        check("rst_req_we", bus.mem_req_we, 0);
        check("rst_req_addr", bus.mem_req_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_fill_valid", bus.fill_valid, 0);
        check("rst_fill_addr", bus.fill_addr, 0);
        check("rst_fill_line", bus.fill_line, 0);
    endtask

    task automatic pick_ready(input int mode, inout bit tog);
        if (mode == 0) bus.mem_req_ready = 1;
        else if (mode == 1) begin
            bus.mem_req_ready = tog;
            tog = ~tog;
        end else bus.mem_req_ready = 1'($urandom % 2);
    endtask

    // One miss end to end; abort>=0 pulls reset once that many read beats have landed.
    task automatic run_miss(input bit dirty, input logic [31:0] ma, input logic [31:0] wa,
                            input logic [511:0] wl, input int mode, input int fwait,
                            input int abort, input bit pat);
        logic [31:0]  rd [16];
        logic [511:0] exp_line;
        logic [31:0]  am, aw;
        int           nw, cyc, gaps;
        bit           tog, acc;
        am = ma & ~32'h3f;
        aw = wa & ~32'h3f;
        for (int i = 0; i < 16; i++) begin
            rd[i] = pat ? 32'h1000 + i : $urandom;
            exp_line[32*i +: 32] = rd[i];
        end
        @(negedge clk);
        check("idle_miss_ready", bus.miss_ready, 1);
        bus.miss_valid = 1;
        bus.miss_addr  = ma;
        bus.wb_addr    = wa;
        bus.wb_dirty   = dirty;
        bus.wb_line    = wl;
        @(negedge clk);
        bus.miss_valid = 0;
        bus.wb_line    = {16{$urandom}};
        check("accept_busy", bus.busy, 1);
        tog = 0;
        if (dirty) begin
            nw = 0;
            cyc = 0;
            while (nw < 16 && cyc < 400) begin
                check("wb_valid", bus.mem_req_valid, 1);
                check("wb_we", bus.mem_req_we, 1);
                check("wb_addr", bus.mem_req_addr, aw + 4 * nw);
                check("wb_data", bus.mem_wdata, wl[32*nw +: 32]);
                pick_ready(mode, tog);
                if (bus.mem_req_ready) nw++;
                @(negedge clk);
                cyc++;
            end
            if (nw < 16) check("wb_timeout", 0, 1);
        end
        cyc = 0;
        acc = 0;
        while (!acc && cyc < 100) begin
            check("rd_valid", bus.mem_req_valid, 1);
            check("rd_we", bus.mem_req_we, 0);
            check("rd_addr", bus.mem_req_addr, am);
            pick_ready(mode, tog);
            acc = bus.mem_req_ready;
            @(negedge clk);
            cyc++;
        end
        if (!acc) check("rd_req_timeout", 0, 1);
        bus.mem_req_ready = 0;
        for (int i = 0; i < 16; i++) begin
            bus.mem_rdata_valid = 0;
            if (abort == i) begin
                rst = 0;
                #1;
                check_reset_outputs();
                @(negedge clk);
                rst = 1;
                return;
            end
            gaps = $urandom % 3;
            repeat (gaps) begin
                check("rd_data_no_req", bus.mem_req_valid, 0);
                check("rd_data_no_fill", bus.fill_valid, 0);
                check("miss_blocked", bus.miss_ready, 0);
                bus.miss_valid = 1'($urandom % 2);
                bus.miss_addr  = $urandom;
                bus.wb_dirty   = 1'($urandom % 2);
                @(negedge clk);
            end
            bus.miss_valid      = 0;
            bus.mem_rdata_valid = 1;
            bus.mem_rdata       = rd[i];
            @(negedge clk);
        end
        for (int w = 0; w <= fwait; w++) begin
            check("fill_valid", bus.fill_valid, 1);
            check("fill_addr", bus.fill_addr, am);
            check("fill_line", bus.fill_line, exp_line);
            check("fill_miss_ready", bus.miss_ready, 0);
            bus.mem_rdata_valid = 1'($urandom % 2);
            bus.mem_rdata       = $urandom;
            bus.fill_ready      = w == fwait;
            @(negedge clk);
        end
        bus.fill_ready      = 0;
        bus.mem_rdata_valid = 0;
        check("fill_drop", bus.fill_valid, 0);
        check("post_fill_ready", bus.miss_ready, 1);
        check("post_fill_busy", bus.busy, 0);
    endtask

    task automatic idle_noise();
        repeat (3) begin
            @(negedge clk);
            check("noise_idle", bus.busy, 0);
            check("noise_no_req", bus.mem_req_valid, 0);
            bus.mem_rdata_valid = 1;
            bus.mem_rdata       = $urandom;
        end
        @(negedge clk);
        bus.mem_rdata_valid = 0;
        check("noise_still_idle", bus.busy, 0);
    endtask

    logic [511:0] wl_a0, wl_r;

    initial begin
        bus.miss_valid = 0;
        bus.miss_addr = 0;
        bus.wb_dirty = 0;
        bus.wb_addr = 0;
        bus.wb_line = 0;
        bus.mem_req_ready = 0;
        bus.mem_rdata_valid = 0;
        bus.mem_rdata = 0;
        bus.fill_ready = 0;
        for (int i = 0; i < 16; i++) wl_a0[32*i +: 32] = 32'hA0 + i;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1;
        run_miss(0, 32'h0001_2345, 32'h0, '0, 0, 0, -1, 1);
        run_miss(1, 32'h0004_0010, 32'h0000_8000, wl_a0, 0, 0, -1, 0);
        run_miss(1, 32'h0007_7777, 32'h0000_8000, wl_a0, 1, 0, -1, 0);
        run_miss(0, 32'h00AB_CDEF, 32'h0, '0, 0, 5, -1, 0);
        run_miss(1, 32'h0000_1234, 32'h0000_9000, wl_a0, 0, 0, 8, 1);
        run_miss(0, 32'h0000_5678, 32'h0, '0, 0, 0, -1, 1);
        idle_noise();
        run_miss(1, 32'h0000_0040, 32'h0001_0000, wl_a0, 2, 1, -1, 0);
        for (int k = 0; k < 25; k++) begin
            for (int i = 0; i < 16; i++) wl_r[32*i +: 32] = $urandom;
            run_miss(1'($urandom % 2), $urandom, $urandom, wl_r, int'($urandom % 3),
                     int'($urandom % 4), -1, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
